// File: rtl/bcd_hc595_display.sv
// bcd_hc595_display
// Scans a 3-digit packed BCD value onto a 74HC595-driven multiplexed
// seven-segment display. Each refresh tick one digit is sent to the shift
// registers as a 16-bit {seg, sel} word, MSB first, and then latched.
// The word includes leading-zero blanking, an 'E' glyph for non-BCD
// nibbles, and the overflow flag shown on digit 0's decimal point.
module bcd_hc595_display #(
  parameter int SCAN_DIV = 50000,
  parameter int SCLK_DIV = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [11:0] q,
  input  logic        Cout,
  input  logic        Ovf_clr,
  output logic        DS,
  output logic        SH_CP,
  output logic        ST_CP,
  output logic        Busy
);

  localparam int TW = $clog2(SCAN_DIV + 1);
  localparam int PW = $clog2(2 * SCLK_DIV + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Active-low common-anode segment pattern; anything above 9 shows 'E'.
  function automatic logic [7:0] seg_enc(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'h86;
    endcase
    return s;
  endfunction

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shreg_q, shreg_d;
  logic [1:0]      dig_q, dig_d;
  logic            ovf_q, ovf_d;
  logic            ds_d, shcp_d, stcp_d, busy_d;
  logic            tick_s, ph_last_s;
  logic [7:0]      seg_s, sel_s;
  logic [15:0]     word_s;

  assign tick_s    = (tick_cnt_q == TW'(SCAN_DIV - 1));
  assign ph_last_s = (ph_q == PW'(2 * SCLK_DIV - 1));

  // Refresh tick divider and overflow flag (clear wins over set).
  always_comb begin
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + TW'(1);
    if (Ovf_clr) begin
      ovf_d = 1'b0;
    end else if (Cout) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Build the {seg, sel} word for the current digit from the live inputs.
  always_comb begin
    seg_s = 8'hFF;
    case (dig_q)
      2'd0: begin
        seg_s = seg_enc(q[3:0]);
        if (ovf_q) begin
          seg_s[7] = 1'b0;
        end else begin
          seg_s[7] = seg_s[7];
        end
      end
      2'd1: begin
        if ((q[11:8] == 4'd0) && (q[7:4] == 4'd0)) begin
          seg_s = 8'hFF;
        end else begin
          seg_s = seg_enc(q[7:4]);
        end
      end
      2'd2: begin
        if (q[11:8] == 4'd0) begin
          seg_s = 8'hFF;
        end else begin
          seg_s = seg_enc(q[11:8]);
        end
      end
      default: seg_s = 8'hFF;
    endcase
    sel_s  = ~(8'h01 << dig_q);
    word_s = {seg_s, sel_s};
  end

  // Frame FSM next state plus the registered output values it implies.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dig_d   = dig_q;
    case (state_q)
      IDLE: begin
        if (tick_s) begin
          state_d = SHIFT;
          shreg_d = word_s;
          bit_d   = 4'd15;
          ph_d    = '0;
        end else begin
          ph_d = '0;
        end
      end
      SHIFT: begin
        if (ph_last_s) begin
          ph_d = '0;
          if (bit_q == 4'd0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      LATCH: begin
        if (ph_last_s) begin
          state_d = IDLE;
          ph_d    = '0;
          dig_d   = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ds_d   = (state_d == SHIFT) && shreg_d[15];
    shcp_d = (state_d == SHIFT) && (ph_d >= PW'(SCLK_DIV));
    stcp_d = (state_d == LATCH) && (ph_d < PW'(SCLK_DIV));
    busy_d = (state_d != IDLE);
  end

  // State, counters, snapshot register and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      ph_q       <= '0;
      bit_q      <= 4'd0;
      shreg_q    <= 16'h0000;
      dig_q      <= 2'd0;
      ovf_q      <= 1'b0;
      DS         <= 1'b0;
      SH_CP      <= 1'b0;
      ST_CP      <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      DS         <= ds_d;
      SH_CP      <= shcp_d;
      ST_CP      <= stcp_d;
      Busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bcd_hc595_display.sv
// Scoreboard bench for bcd_hc595_display: stimulus pushes hand-computed
// frame words, a negedge monitor reassembles frames from DS/SH_CP/ST_CP.
module tb_bcd_hc595_display;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [11:0] q = 12'h000;
  logic        Cout = 1'b0;
  logic        Ovf_clr = 1'b0;
  logic        DS, SH_CP, ST_CP, Busy;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];

  bcd_hc595_display #(.SCAN_DIV(100), .SCLK_DIV(2)) dut (
    .Clk(Clk), .Rst(Rst), .q(q), .Cout(Cout), .Ovf_clr(Ovf_clr),
    .DS(DS), .SH_CP(SH_CP), .ST_CP(ST_CP), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Monitor: rebuild each frame and compare it with the scoreboard.
  logic        prev_sh = 1'b0, prev_st = 1'b0, prev_busy = 1'b0;
  logic [15:0] acc = 16'h0000;
  int          nbits = 0, nst = 0, busy_len = 0;

  always @(negedge Clk) begin
    if (Rst) begin
      prev_sh = 1'b0; prev_st = 1'b0; prev_busy = 1'b0;
      acc = 16'h0000; nbits = 0; nst = 0; busy_len = 0;
    end else begin
      if (Busy) busy_len++;
      if (SH_CP && !prev_sh) begin
        acc = {acc[14:0], DS};
        nbits++;
      end
      if (ST_CP && !prev_st) begin
        nst++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL word: got %h but no frame was expected", acc);
        end else begin
          logic [15:0] exp;
          exp = sb.pop_front();
          if (acc !== exp) begin
            failures++;
            $display("FAIL word: got %h expected %h", acc, exp);
          end
        end
      end
      if (!Busy && prev_busy) begin
        checks++;
        if (busy_len != 68 || nbits != 16 || nst != 1) begin
          failures++;
          $display("FAIL frame_shape: busy=%0d bits=%0d st=%0d expected 68/16/1",
                   busy_len, nbits, nst);
        end
        acc = 16'h0000; nbits = 0; nst = 0; busy_len = 0;
      end
      prev_sh = SH_CP; prev_st = ST_CP; prev_busy = Busy;
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({DS, SH_CP, ST_CP, Busy} !== 4'b0000) begin
      failures++;
      $display("FAIL %s: DS/SH/ST/Busy=%b expected 0000", name, {DS, SH_CP, ST_CP, Busy});
    end
  endtask

  task automatic wait_busy(input logic lvl);
    int n = 0;
    while (Busy !== lvl && n < 300) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (Busy !== lvl) begin
      failures++;
      $display("FAIL busy_timeout: Busy=%b expected %b", Busy, lvl);
    end
  endtask

  task automatic do_frame(input logic [11:0] qv, input logic [15:0] exp,
                          input bit mid, input logic [11:0] mq);
    q = qv;
    sb.push_back(exp);
    wait_busy(1'b1);
    if (mid) begin
      repeat (10) @(negedge Clk);
      q = mq;
    end
    wait_busy(1'b0);
  endtask

  task automatic run_group(input logic [11:0] qv, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2);
    do_frame(qv, e0, 1'b0, qv);
    do_frame(qv, e1, 1'b0, qv);
    do_frame(qv, e2, 1'b0, qv);
  endtask

  task automatic pulse(input bit c, input bit clr);
    @(negedge Clk);
    Cout = c; Ovf_clr = clr;
    @(negedge Clk);
    Cout = 1'b0; Ovf_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check_idle_outputs("reset_state");
    Rst = 1'b0;

    run_group(12'h123, 16'hB0FE, 16'hA4FD, 16'hF9FB);
    run_group(12'h005, 16'h92FE, 16'hFFFD, 16'hFFFB);
    run_group(12'h040, 16'hC0FE, 16'h99FD, 16'hFFFB);
    run_group(12'h000, 16'hC0FE, 16'hFFFD, 16'hFFFB);
    run_group(12'h0A7, 16'hF8FE, 16'h86FD, 16'hFFFB);
    run_group(12'hA00, 16'hC0FE, 16'hC0FD, 16'h86FB);

    pulse(1'b1, 1'b0);
    run_group(12'h000, 16'h40FE, 16'hFFFD, 16'hFFFB);
    run_group(12'h000, 16'h40FE, 16'hFFFD, 16'hFFFB);
    pulse(1'b0, 1'b1);
    run_group(12'h000, 16'hC0FE, 16'hFFFD, 16'hFFFB);
    pulse(1'b1, 1'b1);
    run_group(12'h000, 16'hC0FE, 16'hFFFD, 16'hFFFB);

    do_frame(12'h321, 16'hF9FE, 1'b1, 12'h456);
    do_frame(12'h456, 16'h92FD, 1'b0, 12'h456);
    do_frame(12'h456, 16'h99FB, 1'b0, 12'h456);

    do_frame(12'h012, 16'hA4FE, 1'b0, 12'h012);
    wait_busy(1'b1);
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check_idle_outputs("reset_mid_shift");
    @(negedge Clk);
    Rst = 1'b0;
    run_group(12'h012, 16'hA4FE, 16'hF9FD, 16'hFFFB);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d frames pending, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
